// File: rtl/lb_pkg.sv
// Shared types and helpers for the stencil line buffer: window bit-offset
// mapping and counter sizing.
package lb_pkg;

  // Reference pixel type at the default width; instances size their own ports.
  localparam int LB_DATA_W = 16;
  typedef logic [LB_DATA_W-1:0] pix_t;

  typedef struct packed {
    logic sol;
    logic eol;
    logic sof;
  } lb_sb_t;

  // Bit offset of stencil element (r,c); r=0 oldest row, c=0 oldest column.
  function automatic int st_off(input int r, input int c, input int st_w, input int data_w);
    return (r * st_w + c) * data_w;
  endfunction

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lb_line_mem.sv
// One line of pixel history: single-port memory, combinational
// read-before-write so the old value is seen in the same cycle it is replaced.
module lb_line_mem #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64,
  parameter int AW     = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  always_ff @(posedge clk)
    if (we) mem[addr] <= wr_data;

endmodule

// File: rtl/stencil_line_buffer.sv
// Raster stream to ST_H x ST_W stencil window, one registered output beat.
// Define LB_SIDEBAND_EN to add out_sol / out_eol / out_sof markers.
module stencil_line_buffer
  import lb_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ST_H   = 3,
  parameter int ST_W   = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ST_H*ST_W*DATA_W-1:0] out_stencil,
`ifdef LB_SIDEBAND_EN
  output logic                        out_sol,
  output logic                        out_eol,
  output logic                        out_sof,
`endif
  output logic                        frame_done
);

  localparam int CW    = cnt_w(IMG_W);
  localparam int RW    = cnt_w(IMG_H);
  localparam int WIN_W = ST_H * ST_W * DATA_W;

  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [WIN_W-1:0] win, win_nxt;
  logic [ST_H-1:0][DATA_W-1:0] col_vec;
  logic fire, emit, last_col, last_row, row_ok, col_ok;

  assign in_ready = ~out_valid | out_ready;
  assign fire     = in_valid & in_ready;
  assign last_col = (col == CW'(IMG_W - 1));
  assign last_row = (row == RW'(IMG_H - 1));
  assign emit     = fire & row_ok & col_ok;

  if (ST_H > 1) begin : g_row_ok
    assign row_ok = (row >= RW'(ST_H - 1));
  end else begin : g_row_any
    assign row_ok = 1'b1;
  end

  if (ST_W > 1) begin : g_col_ok
    assign col_ok = (col >= CW'(ST_W - 1));
  end else begin : g_col_any
    assign col_ok = 1'b1;
  end

  // Memory k holds the line k+1 rows above the incoming one and is refilled
  // from memory k-1, so the column vector ripples upward one line per frame row.
  assign col_vec[ST_H-1] = in_data;

  for (genvar k = 0; k < ST_H - 1; k++) begin : g_mem
    logic [DATA_W-1:0] rd, wr;
    if (k == 0) begin : g_first
      assign wr = in_data;
    end else begin : g_chain
      assign wr = g_mem[k-1].rd;
    end
    lb_line_mem #(.DATA_W(DATA_W), .DEPTH(IMG_W), .AW(CW)) u_mem (
      .clk     (clk),
      .we      (fire),
      .addr    (col),
      .wr_data (wr),
      .rd_data (rd)
    );
    assign col_vec[ST_H-2-k] = rd;
  end

  for (genvar r = 0; r < ST_H; r++) begin : g_win_r
    for (genvar c = 0; c < ST_W; c++) begin : g_win_c
      if (c < ST_W - 1) begin : g_shift
        assign win_nxt[st_off(r, c, ST_W, DATA_W) +: DATA_W] = win[st_off(r, c + 1, ST_W, DATA_W) +: DATA_W];
      end else begin : g_load
        assign win_nxt[st_off(r, c, ST_W, DATA_W) +: DATA_W] = col_vec[r];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col         <= '0;
      row         <= '0;
      win         <= '0;
      out_valid   <= 1'b0;
      out_stencil <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= fire & last_col & last_row;
      if (fire) begin
        win <= win_nxt;
        col <= last_col ? '0 : col + CW'(1);
        if (last_col) row <= last_row ? '0 : row + RW'(1);
      end
      if (emit) begin
        out_valid   <= 1'b1;
        out_stencil <= win_nxt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef LB_SIDEBAND_EN
  lb_sb_t sb;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sb <= '0;
    end else if (emit) begin
      sb.sol <= (col == CW'(ST_W - 1));
      sb.eol <= last_col;
      sb.sof <= (row == RW'(ST_H - 1)) && (col == CW'(ST_W - 1));
    end
  end

  assign out_sol = sb.sol;
  assign out_eol = sb.eol;
  assign out_sof = sb.sof;
`endif

endmodule

// File: tb/tb_stencil_line_buffer.sv
// Scoreboard bench: 4x4 frame with a 3x3 stencil, plus a 1x2 legacy instance.
module tb_stencil_line_buffer;

  localparam int DW = 16, IW = 4, IH = 4, SH = 3, SW = 3;
  localparam int SB = SH * SW * DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, in_valid, in_ready, out_valid, out_ready, frame_done;
  logic [DW-1:0] in_data;
  logic [SB-1:0] out_stencil;
  logic v1, ir1, ov1, or1, fd1;
  logic [7:0]  d1;
  logic [15:0] st1;
`ifdef LB_SIDEBAND_EN
  logic out_sol, out_eol, out_sof, sol1, eol1, sof1;
`endif

  stencil_line_buffer #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .ST_H(SH), .ST_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_stencil(out_stencil),
`ifdef LB_SIDEBAND_EN
    .out_sol(out_sol), .out_eol(out_eol), .out_sof(out_sof),
`endif
    .frame_done(frame_done));

  stencil_line_buffer #(.DATA_W(8), .IMG_W(4), .IMG_H(2), .ST_H(1), .ST_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(ir1), .in_data(d1),
    .out_valid(ov1), .out_ready(or1), .out_stencil(st1),
`ifdef LB_SIDEBAND_EN
    .out_sol(sol1), .out_eol(eol1), .out_sof(sof1),
`endif
    .frame_done(fd1));

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model / scoreboard
  logic [SB-1:0] exp_q[$], got_log[$];
  logic [2:0]    sb_q[$];
  logic [15:0]   q1[$];
  int img[IH][IW];
  int mr = 0, mc = 0, fd_exp = 0, fd_got = 0, fd1_got = 0;
  int rdy_mode = 0, hold_cnt = 0;
  bit hold_done = 0, held = 0;
  logic [SB-1:0] held_st;

  function automatic logic [SB-1:0] pk(input int v[9]);
    logic [SB-1:0] s;
    for (int i = 0; i < 9; i++) s[i*DW +: DW] = DW'(v[i]);
    return s;
  endfunction

  function automatic logic [SB-1:0] mk_st();
    logic [SB-1:0] s;
    for (int r = 0; r < SH; r++)
      for (int c = 0; c < SW; c++)
        s[(r*SW + c)*DW +: DW] = DW'(img[mr-SH+1+r][mc-SW+1+c]);
    return s;
  endfunction

  task automatic model_accept(input logic [DW-1:0] d);
    img[mr][mc] = int'(d);
    if (mr >= SH-1 && mc >= SW-1) begin
      exp_q.push_back(mk_st());
      sb_q.push_back({mc == SW-1, mc == IW-1, (mr == SH-1) && (mc == SW-1)});
    end
    if (mr == IH-1 && mc == IW-1) fd_exp++;
    if (mc == IW-1) begin mc = 0; mr = (mr == IH-1) ? 0 : mr + 1; end
    else mc++;
  endtask

  // ---------------- driver
  task automatic cyc(input bit v, input logic [DW-1:0] d, output bit acc);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: begin
        if (out_valid && !hold_done) begin
          out_ready = 1'b0;
          hold_cnt++;
          if (hold_cnt == 5) hold_done = 1;
        end else out_ready = 1'b1;
      end
    endcase
    #1;
    acc = v && in_ready;
    if (acc) model_accept(d);
  endtask

  task automatic send(input logic [DW-1:0] d, input bit gap);
    bit acc = 0;
    int guard = 0;
    if (gap) while ($urandom_range(0, 1) == 1 && guard < 8) begin cyc(0, '0, acc); guard++; end
    guard = 0;
    do begin cyc(1, d, acc); guard++; end while (!acc && guard < 50);
    if (!acc) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: pixel %0d not accepted within 50 cycles", d);
    end
  endtask

  task automatic frame(input int base, input bit gap);
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++) send(DW'(base + r*IW + c), gap);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cyc(0, '0, acc);
  endtask

  // ---------------- monitors
  always begin
    @(negedge clk); #2;
    if (!rst_n) held = 0;
    else begin
      if (held) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_data", out_stencil, held_st);
      end
      if (out_valid && !out_ready) begin
        chk("hold_in_ready", in_ready, 1'b0);
        held = 1; held_st = out_stencil;
      end else held = 0;
      if (out_valid && out_ready) begin
        got_log.push_back(out_stencil);
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_stencil: got %h with empty queue", out_stencil);
        end else begin
          chk("stencil", out_stencil, exp_q.pop_front());
`ifdef LB_SIDEBAND_EN
          chk("sideband", {out_sol, out_eol, out_sof}, sb_q.pop_front());
`endif
        end
      end
      if (frame_done) begin
        fd_got++;
        chk("frame_done", fd_got, fd_exp);
      end
    end
  end

  always begin
    @(negedge clk); #2;
    if (rst_n && ov1 && or1) begin
      if (q1.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL legacy_unexpected: got %h with empty queue", st1);
      end else chk("legacy_pair", st1, q1.pop_front());
    end
    if (rst_n && fd1) fd1_got++;
  end

  // ---------------- stimulus
  initial begin
    bit acc;
    logic [7:0] prev;
    rst_n = 0; in_valid = 0; in_data = '0; out_ready = 1;
    v1 = 0; d1 = '0; or1 = 1; prev = '0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_out_stencil", out_stencil, '0);
    rst_n = 1;
    @(negedge clk); #2;
    chk("rst_in_ready", in_ready, 1'b1);

    // full rate, latency check around pixel 10
    for (int p = 0; p <= 10; p++) send(DW'(p), 0);
    chk("pre_latency", out_valid, 1'b0);
    cyc(0, '0, acc);
    chk("latency", out_valid, 1'b1);
    for (int p = 11; p < 16; p++) send(DW'(p), 0);
    idle(4);
    chk("t1_count", got_log.size(), 4);
    chk("t1_first", got_log[0], pk('{0, 1, 2, 4, 5, 6, 8, 9, 10}));
    chk("t1_second", got_log[1], pk('{1, 2, 3, 5, 6, 7, 9, 10, 11}));

    // backpressure on the first stencil
    got_log.delete();
    rdy_mode = 2; hold_cnt = 0; hold_done = 0;
    frame(0, 0);
    idle(4);
    rdy_mode = 0;
    chk("t2_count", got_log.size(), 4);
    chk("t2_first", got_log[0], pk('{0, 1, 2, 4, 5, 6, 8, 9, 10}));
    chk("t2_last", got_log[3], pk('{5, 6, 7, 9, 10, 11, 13, 14, 15}));

    // random gaps and random out_ready
    got_log.delete();
    rdy_mode = 1;
    frame(300, 1);
    idle(30);
    rdy_mode = 0;
    idle(3);
    chk("t3_count", got_log.size(), 4);

    // back-to-back frames
    got_log.delete();
    frame(0, 0);
    frame(16, 0);
    idle(4);
    chk("t4_count", got_log.size(), 8);
    chk("t4_f2_first", got_log[4], pk('{16, 17, 18, 20, 21, 22, 24, 25, 26}));

    // reset mid-frame after pixel 6
    for (int p = 0; p <= 6; p++) send(DW'(p), 0);
    @(negedge clk);
    in_valid = 0; rst_n = 0; mr = 0; mc = 0;
    @(negedge clk); #2;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_queue", exp_q.size(), 0);
    rst_n = 1;
    got_log.delete();
    frame(200, 0);
    idle(4);
    chk("t5_count", got_log.size(), 4);
    chk("t5_first", got_log[0], pk('{200, 201, 202, 204, 205, 206, 208, 209, 210}));

    // legacy 1x2 instance: pairs {p[n-1], p[n]} for col >= 1
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      v1 = 1; d1 = 8'(n*7 + 3);
      #1;
      chk("legacy_in_ready", ir1, 1'b1);
      if (n % 4 >= 1) q1.push_back({d1, prev});
      prev = d1;
    end
    @(negedge clk);
    v1 = 0;
    idle(4);

    chk("queue_empty", exp_q.size(), 0);
    chk("frame_done_total", fd_got, fd_exp);
    chk("legacy_queue_empty", q1.size(), 0);
    chk("legacy_frame_done", fd1_got, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stencil_line_buffer.md
Name: stencil_line_buffer

Overview:
Parametrised streaming line buffer that turns a raster pixel stream into a full ST_H x ST_W stencil window per output beat. It is the next generation of the fixed 1x2 8-bit line buffer, generalised in data width, image width, stencil height and stencil width. It adds a valid/ready handshake, frame-position tracking and a frame-done pulse. It sits between an update stream and a kernel__* compute block.

Parameters:
DATA_W, 16, pixel width in bits
IMG_W, 64, pixels per line (>= ST_W)
IMG_H, 64, lines per frame (>= ST_H)
ST_H, 3, stencil rows (>= 1); ST_H-1 line memories
ST_W, 3, stencil columns (>= 1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous reset, active low
in_valid  in  1  input pixel valid
in_ready  out  1  block can accept a pixel this cycle
in_data  in  DATA_W  input pixel, raster order
out_valid  out  1  out_stencil holds a complete window
out_ready  in  1  consumer accepts the window
out_stencil  out  ST_H*ST_W*DATA_W  window; element (r,c) is at bits [(r*ST_W+c)*DATA_W +: DATA_W]; r=0 is the oldest row, c=0 the oldest column
frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted

Behaviour:
- Reset: clk with rst_n=0 clears col/row counters, window registers, out_valid, out_stencil and frame_done to 0. Line-memory contents are don't-care. in_ready=1 from the first cycle after reset. Reset mid-frame discards the partial frame; the next accepted pixel is (row 0, col 0).
- Accept: in_fire = in_valid & in_ready. in_ready = ~out_valid | out_ready, so there is a single output register and no bubble at full rate.
- On in_fire:
  - Line memories form a column shift: mem[k] reads the value at address col before the write, and mem[k] is written with mem[k-1] (mem[0] takes in_data).
  - The column vector {mem[ST_H-2]..mem[0], in_data} shifts into the ST_W-deep window shift register.
- Counters: col increments and wraps at IMG_W-1 → 0, then row increments. row wraps at IMG_H-1 → 0 and asserts frame_done on that same fire.
- Output: the window is emitted when, at the time of the accepted pixel, row >= ST_H-1 and col >= ST_W-1. out_valid rises the cycle after the fire; latency is 1 cycle. No stencils are emitted for warm-up positions; there is no edge padding. Stencils per frame = (IMG_H-ST_H+1)*(IMG_W-ST_W+1).
- Hold: out_valid & ~out_ready holds out_stencil stable and deasserts in_ready. No input is accepted and no state advances.
- out_valid clears after out_ready when no new window is produced the same cycle. If out_ready and a new window-producing fire occur together, out_valid stays 1 with the new data.
- Window contents across a line wrap: the window keeps shifting, so the first ST_W-1 positions of each line contain stale columns. They are suppressed by the col condition.
- Degenerate sizes: ST_H=1 means no memories. ST_W=1 means the window is the column vector only.
- Arithmetic: pure data movement; no width change.

Optional Feature:
- Macro: LB_SIDEBAND_EN.
- Defined: adds outputs out_sol (stencil is the first of its output line, col==ST_W-1), out_eol (col==IMG_W-1) and out_sof (first stencil of frame). Each is registered with and held alongside out_stencil.
- Undefined: these ports are absent; behaviour is otherwise identical.

Decomposition:
- Package lb_pkg: pixel typedef parameterised by DATA_W, the stencil index function (r,c) → bit offset, and counter width function clog2(IMG_W), clog2(IMG_H).
- One sub-module, lb_line_mem: single-port read-before-write memory, depth IMG_W, width DATA_W, instantiated ST_H-1 times.

Test Plan:
- Reset then full-rate frame: IMG_W=4, IMG_H=4, ST 3x3, pixel = row*4+col, out_ready=1 → exactly 4 stencils. The first arrives 1 cycle after pixel 10 with elements {0,1,2,4,5,6,8,9,10}, then {1,2,3,5,6,7,9,10,11}. frame_done pulses with pixel 15.
- Backpressure: same frame, out_ready=0 for 5 cycles at the first stencil → out_stencil stable, in_ready=0, no pixel lost. The stencil sequence is identical to the previous test.
- Random in_valid gaps (50%) with random out_ready → stencil stream matches the reference model; no duplicates or drops.
- Back-to-back frames without reset → the second frame starts at (0,0) and its first stencil uses only second-frame rows (values 16+...).
- rst_n=0 for one cycle after pixel 6 → out_valid=0; the next frame's first stencil is correct.
- ST_H=1, ST_W=2, DATA_W=8 → reproduces legacy 1x2 behaviour: pairs {p[n-1], p[n]} for col >= 1.
